// File: rtl/decimator_mc.sv
// Multi-channel TDM decimator: keeps one frame in every cfg_rate, selected by cfg_phase, behind a 2-entry output FIFO.
// Optional macro DECIM_DROP_EN: never backpressure; drop kept beats when the FIFO is full and add a drop_cnt output.
module decimator_mc #(
  parameter int BITS    = 10,
  parameter int CH      = 4,
  parameter int R_MAX   = 16,
  parameter int R_DEF   = 2,
  parameter int R_BITS  = $clog2(R_MAX + 1),
  parameter int CH_BITS = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [R_BITS-1:0]  cfg_rate,
  input  logic [R_BITS-1:0]  cfg_phase,
  input  logic               cfg_load,
  input  logic [BITS-1:0]    in_data,
  input  logic [CH_BITS-1:0] in_ch,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BITS-1:0]    out_data,
  output logic [CH_BITS-1:0] out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sync_err
`ifdef DECIM_DROP_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  logic [R_BITS-1:0]  rate;
  logic [R_BITS-1:0]  phase;
  logic [R_BITS-1:0]  frame_cnt;
  logic [CH_BITS-1:0] exp_ch;
  logic [R_BITS-1:0]  load_rate;
  logic [R_BITS-1:0]  load_phase;

  logic               skid_valid;
  logic [BITS-1:0]    skid_data;
  logic [CH_BITS-1:0] skid_ch;

  logic keep;
  logic fifo_full;
  logic accept;
  logic ch_ok;
  logic push_req;
  logic push;
  logic pop;
  logic last_ch;

  // Clamp the requested rate/phase into the legal range
  always_comb begin
    load_rate  = cfg_rate;
    load_phase = cfg_phase;
    if (cfg_rate == {R_BITS{1'b0}}) begin
      load_rate = R_BITS'(1);
    end else if (cfg_rate > R_BITS'(R_MAX)) begin
      load_rate = R_BITS'(R_MAX);
    end else begin
      load_rate = cfg_rate;
    end
    if (cfg_phase >= load_rate) begin
      load_phase = load_rate - R_BITS'(1);
    end else begin
      load_phase = cfg_phase;
    end
  end

  // Handshake and FIFO push/pop decisions
  always_comb begin
    keep      = (frame_cnt == phase);
    fifo_full = skid_valid;
`ifdef DECIM_DROP_EN
    in_ready  = rst_n && !cfg_load;
`else
    in_ready  = rst_n && !cfg_load && (!keep || !fifo_full);
`endif
    accept    = in_valid && in_ready;
    ch_ok     = (in_ch == exp_ch);
    last_ch   = (exp_ch == CH_BITS'(CH - 1));
    push_req  = accept && ch_ok && keep;
    pop       = out_valid && out_ready;
    push      = push_req && (!fifo_full || pop);
  end

  // Configuration and frame/channel tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate      <= R_BITS'(R_DEF);
      phase     <= {R_BITS{1'b0}};
      frame_cnt <= {R_BITS{1'b0}};
      exp_ch    <= {CH_BITS{1'b0}};
    end else if (cfg_load) begin
      rate      <= load_rate;
      phase     <= load_phase;
      frame_cnt <= {R_BITS{1'b0}};
      exp_ch    <= {CH_BITS{1'b0}};
    end else if (accept) begin
      if (!ch_ok) begin
        // Out-of-order tag: resynchronise on the next channel-0 beat
        frame_cnt <= {R_BITS{1'b0}};
        exp_ch    <= {CH_BITS{1'b0}};
      end else if (last_ch) begin
        exp_ch <= {CH_BITS{1'b0}};
        if (frame_cnt == rate - R_BITS'(1)) begin
          frame_cnt <= {R_BITS{1'b0}};
        end else begin
          frame_cnt <= frame_cnt + R_BITS'(1);
        end
      end else begin
        exp_ch <= exp_ch + CH_BITS'(1);
      end
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // Channel-order violation pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= accept && !ch_ok;
    end
  end

  // Output FIFO: registered head plus one skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= {BITS{1'b0}};
      out_ch     <= {CH_BITS{1'b0}};
      skid_valid <= 1'b0;
      skid_data  <= {BITS{1'b0}};
      skid_ch    <= {CH_BITS{1'b0}};
    end else if (skid_valid) begin
      if (pop) begin
        out_data <= skid_data;
        out_ch   <= skid_ch;
        if (push) begin
          skid_data <= in_data;
          skid_ch   <= in_ch;
        end else begin
          skid_valid <= 1'b0;
        end
      end else begin
        skid_valid <= 1'b1;
      end
    end else if (push && (!out_valid || pop)) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_ch    <= in_ch;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ch    <= in_ch;
    end else if (pop) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef DECIM_DROP_EN
  // Saturating count of kept beats lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'd0;
    end else if (cfg_load) begin
      drop_cnt <= 16'd0;
    end else if (push_req && !push && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

endmodule
